// File: rtl/cell_pos_streamer_pkg.sv
// Shared definitions for the cell position streamer: FSM encoding and the
// fixed geometry of the cell position RAM.
package cell_pos_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN
  } state_t;

  localparam int CELL_RD_LATENCY = 2;
  localparam int COUNT_ADDR      = 0;

endpackage

// File: rtl/pos_skid_fifo.sv
// Small synchronous show-ahead FIFO holding {pos, id, last} entries between
// the RAM read pipeline and the output stream.
module pos_skid_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop    = pop && !empty;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem[rd_ptr];

  // NOTE: non-blocking (<=) for every register so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cell_pos_streamer.sv
// Reads the particle count of one cell, then streams every particle position
// from the cell RAM onto a valid/ready interface without loss under backpressure.
module cell_pos_streamer
  import cell_pos_streamer_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cell_particle_num,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  output logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int FIFO_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int L          = CELL_RD_LATENCY;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                  state_q, state_d;
  logic                    wait_q;
  logic                    done_d, done_q;
  logic                    count_err_q;
  logic [ADDR_WIDTH-1:0]   cnt_q, next_addr_q;
  logic [ADDR_WIDTH-1:0]   raw_cnt, clamped_cnt;
  logic                    cnt_over;
  logic                    issue, issue_last, credit_ok;

  logic [L-1:0]                 pipe_valid, pipe_last;
  logic [L-1:0][ADDR_WIDTH-1:0] pipe_addr;

  logic                  push, pop;
  logic [FIFO_WIDTH-1:0] head_data;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0] head_pos;
  logic [ADDR_WIDTH-1:0] head_id;
  logic                  head_last;

  assign raw_cnt     = rd_data[ADDR_WIDTH-1:0];
  assign cnt_over    = raw_cnt > MAX_CNT;
  assign clamped_cnt = cnt_over ? MAX_CNT : raw_cnt;
  assign issue_last  = (next_addr_q == cnt_q);

  // Pop in the same cycle is not credited, so a push can never meet a full FIFO.
  assign credit_ok = ($countones(pipe_valid) + int'(fifo_count)) < FIFO_DEPTH;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = RD_CNT;
      RD_CNT: begin
        rd_en   = 1'b1;
        rd_addr = ADDR_WIDTH'(COUNT_ADDR);
        state_d = WAIT_CNT;
      end
      WAIT_CNT: begin
        if (wait_q) begin
          if (clamped_cnt == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (credit_ok) begin
          issue   = 1'b1;
          rd_en   = 1'b1;
          rd_addr = next_addr_q;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_q      <= 1'b0;
      done_q      <= 1'b0;
      count_err_q <= 1'b0;
      cnt_q       <= '0;
      next_addr_q <= '0;
      pipe_valid  <= '0;
      pipe_last   <= '0;
      pipe_addr   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      wait_q  <= (state_q == WAIT_CNT) && !wait_q;
      if (state_q == IDLE && start) count_err_q <= 1'b0;
      if (state_q == WAIT_CNT && wait_q) begin
        cnt_q       <= clamped_cnt;
        next_addr_q <= ADDR_WIDTH'(1);
        if (cnt_over) count_err_q <= 1'b1;
      end
      if (issue && !issue_last) next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
      pipe_valid <= {pipe_valid[L-2:0], issue};
      pipe_last  <= {pipe_last[L-2:0], issue_last};
      pipe_addr  <= {pipe_addr[L-2:0], next_addr_q};
    end
  end

  assign push = pipe_valid[L-1];
  assign pop  = out_valid && out_ready;

  pos_skid_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({rd_data, pipe_addr[L-1], pipe_last[L-1]}),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

  assign {head_pos, head_id, head_last} = head_data;

  // Head is gated while empty so stale storage never shows on the outputs.
  assign out_valid         = !fifo_empty;
  assign out_pos           = out_valid ? head_pos  : '0;
  assign out_id            = out_valid ? head_id   : '0;
  assign out_last          = out_valid && head_last;
  assign busy              = (state_q != IDLE);
  assign done              = done_q;
  assign cell_particle_num = cnt_q;
  assign count_err         = count_err_q;
  assign wr_en             = 1'b0;

endmodule
